// File: rtl/control_unit_if.sv
// Control bus between control_unit and the datapath: instruction in, datapath
// control and debug state out. The control unit is the master side.
interface control_unit_if #(
  parameter int DADDR_W = 8
) ();
  logic [15:0]        IR;
  logic               PC_Clr;
  logic               PC_Up;
  logic               IR_Ld;
  logic [DADDR_W-1:0] D_Addr;
  logic               D_Wr;
  logic               RF_s;
  logic [3:0]         RF_W_Addr;
  logic [3:0]         RF_Ra_Addr;
  logic [3:0]         RF_Rb_Addr;
  logic               RF_W_En;
  logic [2:0]         ALU_s0;
  logic [3:0]         State;
  logic [3:0]         NextState;
  logic               Halted;

  modport master (
    input  IR,
    output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s,
           RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, RF_W_En, ALU_s0,
           State, NextState, Halted
  );

  modport slave (
    output IR,
    input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s,
           RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, RF_W_En, ALU_s0,
           State, NextState, Halted
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle processor control FSM (fetch/decode/execute, Moore outputs plus IR fields).
// Optional CTRL_SINGLE_STEP_EN adds a Step input that gates each Fetch.
module control_unit #(
  parameter int DADDR_W = 8
) (
  input  logic           Clk,
  input  logic           Reset,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic           Step,
`endif
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  state_t  state;
  state_t  nxt;
  logic    fetch_go;
  logic [3:0] opcode;

  assign opcode = bus.IR[15:12];

`ifdef CTRL_SINGLE_STEP_EN
  assign fetch_go = Step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else        state <= nxt;
  end

  always_comb begin
    nxt = S_INIT;
    case (state)
      S_INIT:   nxt = S_FETCH;
      S_FETCH:  nxt = fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_NOOP:  nxt = S_NOOP;
          OP_STORE: nxt = S_STORE;
          OP_LOAD:  nxt = S_LOADA;
          OP_ADD:   nxt = S_ADD;
          OP_SUB:   nxt = S_SUB;
          OP_HALT:  nxt = S_HALT;
          default:  nxt = S_NOOP;
        endcase
      end
      S_LOADA:  nxt = S_LOADB;
      S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_INIT;
    endcase
  end

  // Debug NextState reports Init while reset is held, since that is what State will hold.
  assign bus.State     = state;
  assign bus.NextState = Reset ? nxt : S_INIT;

  always_comb begin
    bus.PC_Clr     = 1'b0;
    bus.PC_Up      = 1'b0;
    bus.IR_Ld      = 1'b0;
    bus.D_Addr     = '0;
    bus.D_Wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_Addr  = '0;
    bus.RF_Ra_Addr = '0;
    bus.RF_Rb_Addr = '0;
    bus.RF_W_En    = 1'b0;
    bus.ALU_s0     = 3'b000;
    bus.Halted     = 1'b0;
    case (state)
      S_INIT: bus.PC_Clr = 1'b1;
      S_FETCH: begin
        bus.IR_Ld = fetch_go;
        bus.PC_Up = fetch_go;
      end
      S_LOADA: begin
        bus.D_Addr    = bus.IR[DADDR_W+3:4];
        bus.RF_W_Addr = bus.IR[3:0];
      end
      // Synchronous RAM data is valid one cycle after the address, so the write lands here.
      S_LOADB: begin
        bus.D_Addr    = bus.IR[DADDR_W+3:4];
        bus.RF_W_Addr = bus.IR[3:0];
        bus.RF_s      = 1'b1;
        bus.RF_W_En   = 1'b1;
      end
      S_STORE: begin
        bus.RF_Ra_Addr = bus.IR[11:8];
        bus.D_Addr     = bus.IR[DADDR_W-1:0];
        bus.ALU_s0     = 3'b000;
        bus.D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_Addr = bus.IR[11:8];
        bus.RF_Rb_Addr = bus.IR[7:4];
        bus.RF_W_Addr  = bus.IR[3:0];
        bus.RF_W_En    = 1'b1;
        bus.ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT: bus.Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected outputs are queued when an
// instruction is presented and compared at each falling clock edge.
module tb_control_unit;

  logic Clk;
  logic Reset;
`ifdef CTRL_SINGLE_STEP_EN
  logic Step;
`endif

  control_unit_if #(.DADDR_W(8)) bus ();

  control_unit #(.DADDR_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
`ifdef CTRL_SINGLE_STEP_EN
    .Step  (Step),
`endif
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [37:0] v;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (st %0d/%0d)", tag, got, want, got[37:34], want[37:34]);
    end
  endtask

  // Packing: State, NextState, PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, W, Ra, Rb, W_En, ALU_s0, Halted
  function automatic logic [37:0] ev(input int st, input int nst, input bit pcclr, input bit pcup,
                                     input bit irld, input int da, input bit dwr, input bit rfs,
                                     input int wa, input int ra, input int rb, input bit wen,
                                     input int alu, input bit halt);
    return {4'(st), 4'(nst), pcclr, pcup, irld, 8'(da), dwr, rfs,
            4'(wa), 4'(ra), 4'(rb), wen, 3'(alu), halt};
  endfunction

  function automatic logic [37:0] obs();
    return {bus.State, bus.NextState, bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Addr, bus.D_Wr,
            bus.RF_s, bus.RF_W_Addr, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_En, bus.ALU_s0,
            bus.Halted};
  endfunction

  function automatic logic [37:0] e_reset();
    return ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input string tag, input logic [37:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      @(negedge Clk);
      e = q.pop_front();
      check(e.tag, obs(), e.v);
    end
  endtask

  // Expected outputs derived from the instruction fields, one entry per cycle after Fetch.
  task automatic push_exec(input logic [15:0] ins);
    logic [3:0] op;
    int d_lo, d_hi, ra, rb, wr;
    op   = ins[15:12];
    ra   = int'(ins[11:8]);
    rb   = int'(ins[7:4]);
    wr   = int'(ins[3:0]);
    d_hi = int'(ins[11:4]);
    d_lo = int'(ins[7:0]);
    case (op)
      4'h1: begin
        push("decode_st", ev(2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("store", ev(6, 1, 0, 0, 0, d_lo, 1, 0, 0, ra, 0, 0, 0, 0));
      end
      4'h2: begin
        push("decode_ld", ev(2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("loada", ev(4, 5, 0, 0, 0, d_hi, 0, 0, wr, 0, 0, 0, 0, 0));
        push("loadb", ev(5, 1, 0, 0, 0, d_hi, 0, 1, wr, 0, 0, 1, 0, 0));
      end
      4'h3: begin
        push("decode_add", ev(2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("add", ev(7, 1, 0, 0, 0, 0, 0, 0, wr, ra, rb, 1, 1, 0));
      end
      4'h4: begin
        push("decode_sub", ev(2, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("sub", ev(8, 1, 0, 0, 0, 0, 0, 0, wr, ra, rb, 1, 2, 0));
      end
      4'h5: begin
        push("decode_halt", ev(2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
          push("halt", ev(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      default: begin
        push("decode_nop", ev(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("noop", ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    endcase
  endtask

  task automatic run_fetch();
    push("fetch", ev(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();
  endtask

  task automatic run_instr(input logic [15:0] ins);
    run_fetch();
    bus.IR = ins;
    push_exec(ins);
    drain();
  endtask

  task automatic release_reset();
    @(posedge Clk);
    #1 Reset = 1'b1;
    push("init", ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b0;
    bus.IR = 16'h0000;
`ifdef CTRL_SINGLE_STEP_EN
    Step   = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("in_reset", obs(), e_reset());
    end
    release_reset();

    run_instr(16'h21B4);
    run_instr(16'h3125);
    run_instr(16'h4125);
    run_instr(16'h1380);
    run_instr(16'hF000);
    run_instr(16'h0ABC);
    run_instr(16'h2FF0);
    run_instr(16'h3FED);
    run_instr(16'h10A5);
    run_instr(16'h4E0F);
    run_instr(16'h5000);

    // Asynchronous exit from Halt, observed before the next rising edge.
    #2 Reset = 1'b0;
    #1 check("halt_async_rst", obs(), e_reset());
    @(negedge Clk);
    check("halt_rst_hold", obs(), e_reset());
    release_reset();
    run_instr(16'h7123);

    // Reset asserted while in LoadA: no register-file write may follow.
    run_fetch();
    bus.IR = 16'h21B4;
    push("decode_ld", ev(2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("loada", ev(4, 5, 0, 0, 0, 8'h1B, 0, 0, 4, 0, 0, 0, 0, 0));
    drain();
    #1 Reset = 1'b0;
    #1 check("loada_async_rst", obs(), e_reset());
    @(negedge Clk);
    check("loada_rst_hold", obs(), e_reset());
    release_reset();
    run_instr(16'h3125);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter: DADDR_W, 8, data-memory address width (taken from IR[DADDR_W-1:0] or IR[11:4]; only 8 is supported).
REQ-002 SHALL have port: Clk  input  1  system clock, rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: IR  input  16  instruction register contents; opcode is IR[15:12].
REQ-005 SHALL have port: PC_Clr / PC_Up / IR_Ld  output  1 each  program-counter clear, program-counter increment, IR load.
REQ-006 SHALL have port: D_Addr  output  8  data-memory address.
REQ-007 SHALL have port: D_Wr  output  1  data-memory write enable.
REQ-008 SHALL have port: RF_s  output  1  register-file write-data select (1 = memory, 0 = ALU).
REQ-009 SHALL have port: RF_W_Addr / RF_Ra_Addr / RF_Rb_Addr  output  4 each  register-file write address and read addresses.
REQ-010 SHALL have port: RF_W_En  output  1  register-file write enable.
REQ-011 SHALL have port: ALU_s0  output  3  ALU function: 000 pass A, 001 add, 010 subtract.
REQ-012 SHALL have port: State / NextState  output  4 each  current and next FSM state, for debug.
REQ-013 SHALL have port: Halted  output  1  high while in Halt.

Function
REQ-014 SHALL use the state encoding Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9; codes 10-15 are unreachable and SHALL map to Init.
REQ-015 SHALL use the opcodes 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT; opcodes 6-F SHALL behave as NOOP.
REQ-016 SHALL follow these transitions: Init->Fetch; Fetch->Decode; Decode->state selected by opcode; LoadA->LoadB; NoOp, LoadB, Store, Add and Sub ->Fetch; Halt->Halt until reset.
REQ-017 SHALL generate all outputs combinationally from State and IR only (Moore plus IR fields); NextState SHALL equal the value that State takes at the next edge.
REQ-018 SHALL drive the following in Init: PC_Clr=1 and all other enables 0.
REQ-019 SHALL drive the following in Fetch: IR_Ld=1 and PC_Up=1 (single cycle), with all other enables 0.
REQ-020 SHALL drive no enables in Decode or NoOp.
REQ-021 SHALL implement LOAD (Rd <- D[IR[11:4]]), with RF_W_Addr=IR[3:0] and D_Addr=IR[11:4] in both LoadA and LoadB; LoadA SHALL assert no write; LoadB SHALL assert RF_s=1 and RF_W_En=1 to cover the 1-cycle synchronous RAM read.
REQ-022 SHALL implement STORE (D[IR[7:0]] <- Ra) in the Store state: RF_Ra_Addr=IR[11:8], D_Addr=IR[7:0], ALU_s0=000, D_Wr=1.
REQ-023 SHALL implement ADD/SUB (Rd <- Ra op Rb) in the Add/Sub state: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_s=0, RF_W_En=1, and ALU_s0=001 or 010 respectively.
REQ-024 SHALL drive address outputs to 0 in states where they are unused.
REQ-025 SHALL take 3 cycles from Fetch to the next Fetch for NOOP/STORE/ADD/SUB, and 4 cycles for LOAD.
REQ-026 SHALL assert no enable other than Halted in Halt; PC_Up and IR_Ld SHALL never assert again until reset.
REQ-027 SHALL give D_Wr and RF_W_En mutually exclusive assertion in every state.

Reset
REQ-028 SHALL, while Reset=0, asynchronously force State to Init regardless of the current state, including mid-LOAD and Halt.
REQ-029 SHALL, while in reset, present the outputs PC_Clr=1, everything else 0, and State=0.
REQ-030 SHALL leave Init on the first rising Clk edge after Reset returns to 1 (Init lasts at least one cycle).

Configuration
REQ-031 SHALL, when macro CTRL_SINGLE_STEP_EN is defined, add the port Step (input, 1) and hold State in Fetch with all enables 0 until Step=1 is sampled on a rising edge, so that exactly one instruction executes per Step pulse; Fetch outputs of REQ-019 SHALL assert only in the cycle Step=1.
REQ-032 SHALL, without CTRL_SINGLE_STEP_EN, have no Step port and let Fetch always last exactly one cycle.

Verification
REQ-033 SHALL verify reset: hold Reset=0 for 3 cycles -> State=0, PC_Clr=1, all writes 0; release -> State sequence 0,1,2.
REQ-034 SHALL verify LOAD: IR=16'h21B4 -> states 2,4,5,1; D_Addr=8'h1B in 4 and 5; RF_W_En=1, RF_s=1 and RF_W_Addr=4 only in 5.
REQ-035 SHALL verify ADD/SUB: IR=16'h3125 -> state 7 with Ra=1, Rb=2, W=5, ALU_s0=001; IR=16'h4125 -> state 8 with ALU_s0=010.
REQ-036 SHALL verify STORE: IR=16'h1380 -> state 6 with RF_Ra_Addr=3, D_Addr=8'h80, D_Wr=1, RF_W_En=0.
REQ-037 SHALL verify HALT: IR=16'h5000 -> state 9 held for 10+ cycles, Halted=1, PC_Up never 1; Reset pulse -> State=0 asynchronously before the next edge.
REQ-038 SHALL verify illegal opcode and mid-op reset: IR=16'hF000 -> state 3 then 1; Reset=0 during LoadA -> State=0 immediately with no RF write.
